// File: rtl/relu_share_pkg.sv
// Shared types for the ReLU activation-unit arbiter: FSM states, in-flight tag, word width.
package relu_share_pkg;

    localparam int ACC_W    = 32;
    // Tag id field is sized for the largest supported requester count (16).
    localparam int TAG_ID_W = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic [TAG_ID_W-1:0] id;
        logic                last;
    } tag_t;

endpackage

// File: rtl/relu_tag_fifo.sv
// Synchronous tag FIFO; a push while full is accepted only alongside a pop.
module relu_tag_fifo #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_b,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/relu_share_arb.sv
// Round-robin, burst-locking arbiter sharing one pipelined ReLU unit among NREQ requesters.
// Optional per-requester accept counters under RELU_SHARE_ARB_PERF_EN.
module relu_share_arb
    import relu_share_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int IDW   = 2,
    parameter int DATAW = 8,
    parameter int TAGD  = 8
) (
    input  logic                  clk,
    input  logic                  rst_b,
    input  logic [NREQ-1:0]       req_vld,
    input  logic [NREQ-1:0]       req_last,
    input  logic [NREQ*ACC_W-1:0] req_data,
    output logic [NREQ-1:0]       req_rdy,
    output logic                  act_vld,
    output logic [ACC_W-1:0]      act_data,
    input  logic                  act_res_vld,
    input  logic [DATAW-1:0]      act_res_data,
    output logic                  rsp_vld,
    output logic [IDW-1:0]        rsp_id,
    output logic [DATAW-1:0]      rsp_data,
    output logic                  rsp_last,
    output logic                  busy,
    output logic                  err_orphan
`ifdef RELU_SHARE_ARB_PERF_EN
    ,
    input  logic                  perf_clr,
    output logic [NREQ*16-1:0]    perf_cnt
`endif
);
    // Handshake: a word moves on requester i when req_vld[i] & req_rdy[i];
    // req_rdy never depends on req_vld of a different requester while locked.
    localparam int CW = $clog2(TAGD) + 1;

    arb_state_t     state, state_nxt;
    logic [IDW-1:0] ptr, ptr_nxt;
    logic [IDW-1:0] owner, owner_nxt;
    logic [IDW-1:0] win_id, gnt_id;
    logic           win_vld, gnt_ok;
    logic [NREQ-1:0] rdy_raw;
    logic           hs, hs_last;
    logic [ACC_W-1:0] hs_data;
    int             idx;

    tag_t           act_tag, pop_tag;
    logic           fifo_full, fifo_empty, fifo_pop;
    logic [CW-1:0]  fifo_count;
    logic           occ_full;

    // Counts the word already registered for push this cycle, ignoring any pop.
    assign occ_full = fifo_full | ((fifo_count == CW'(TAGD - 1)) & act_vld);

    always_comb begin
        win_vld = 1'b0;
        win_id  = ptr;
        idx     = 0;
        // Descending scan so the smallest offset from ptr wins last.
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % NREQ;
            if (req_vld[idx]) begin
                win_vld = 1'b1;
                win_id  = IDW'(idx);
            end
        end
    end

    always_comb begin
        gnt_ok  = 1'b0;
        gnt_id  = win_id;
        rdy_raw = '0;
        if (!occ_full) begin
            case (state)
                IDLE: begin
                    gnt_ok = win_vld;
                    gnt_id = win_id;
                end
                BURST: begin
                    gnt_ok = 1'b1;
                    gnt_id = owner;
                end
                default: ;
            endcase
        end
        if (gnt_ok) rdy_raw[gnt_id] = 1'b1;
    end

    assign req_rdy = rdy_raw & {NREQ{rst_b}};
    assign hs      = gnt_ok & req_vld[gnt_id];
    assign hs_last = req_last[gnt_id];
    assign hs_data = req_data[int'(gnt_id)*ACC_W +: ACC_W];

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        owner_nxt = owner;
        if (hs) begin
            if (hs_last) begin
                state_nxt = IDLE;
                ptr_nxt   = (int'(gnt_id) == NREQ - 1) ? '0 : gnt_id + 1'b1;
            end else begin
                state_nxt = BURST;
                owner_nxt = gnt_id;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state <= IDLE;
            ptr   <= '0;
            owner <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            owner <= owner_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            act_vld  <= 1'b0;
            act_data <= '0;
            act_tag  <= '0;
        end else begin
            act_vld <= hs;
            if (hs) begin
                act_data     <= hs_data;
                act_tag.id   <= TAG_ID_W'(gnt_id);
                act_tag.last <= hs_last;
            end
        end
    end

    assign fifo_pop = act_res_vld & ~fifo_empty;

    relu_tag_fifo #(
        .WIDTH ($bits(tag_t)),
        .DEPTH (TAGD)
    ) u_tag_fifo (
        .clk       (clk),
        .rst_b     (rst_b),
        .push      (act_vld),
        .push_data (act_tag),
        .pop       (fifo_pop),
        .pop_data  (pop_tag),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            rsp_vld    <= 1'b0;
            rsp_id     <= '0;
            rsp_data   <= '0;
            rsp_last   <= 1'b0;
            err_orphan <= 1'b0;
        end else begin
            rsp_vld <= fifo_pop;
            if (fifo_pop) begin
                rsp_id   <= pop_tag.id[IDW-1:0];
                rsp_data <= act_res_data;
                rsp_last <= pop_tag.last;
            end
            if (act_res_vld & fifo_empty) err_orphan <= 1'b1;
        end
    end

    assign busy = (state == BURST) | ~fifo_empty;

`ifdef RELU_SHARE_ARB_PERF_EN
    for (genvar g = 0; g < NREQ; g++) begin : g_perf
        logic [15:0] cnt_q;
        always_ff @(posedge clk or negedge rst_b) begin
            if (!rst_b) begin
                cnt_q <= '0;
            end else if (perf_clr) begin
                cnt_q <= '0;
            end else if (hs && (int'(gnt_id) == g) && (cnt_q != 16'hFFFF)) begin
                cnt_q <= cnt_q + 16'd1;
            end
        end
        assign perf_cnt[16*g +: 16] = cnt_q;
    end
`endif

endmodule

// File: tb/tb_relu_share_arb.sv
// Directed bench for relu_share_arb: queue-based requester drivers, stub ReLU unit, tag scoreboard.
module tb_relu_share_arb;

    localparam int NREQ  = 4;
    localparam int IDW   = 2;
    localparam int DATAW = 8;
    localparam int TAGD  = 8;
    localparam int SRCN  = 64;

    logic                  clk = 1'b0;
    logic                  rst_b = 1'b0;
    logic [NREQ-1:0]       req_vld;
    logic [NREQ-1:0]       req_last;
    logic [NREQ*32-1:0]    req_data;
    logic [NREQ-1:0]       req_rdy;
    logic                  act_vld;
    logic [31:0]           act_data;
    logic                  act_res_vld;
    logic [DATAW-1:0]      act_res_data;
    logic                  rsp_vld;
    logic [IDW-1:0]        rsp_id;
    logic [DATAW-1:0]      rsp_data;
    logic                  rsp_last;
    logic                  busy;
    logic                  err_orphan;
`ifdef RELU_SHARE_ARB_PERF_EN
    logic                  perf_clr;
    logic [NREQ*16-1:0]    perf_cnt;
`endif

    relu_share_arb #(.NREQ(NREQ), .IDW(IDW), .DATAW(DATAW), .TAGD(TAGD)) dut (
        .clk          (clk),
        .rst_b        (rst_b),
        .req_vld      (req_vld),
        .req_last     (req_last),
        .req_data     (req_data),
        .req_rdy      (req_rdy),
        .act_vld      (act_vld),
        .act_data     (act_data),
        .act_res_vld  (act_res_vld),
        .act_res_data (act_res_data),
        .rsp_vld      (rsp_vld),
        .rsp_id       (rsp_id),
        .rsp_data     (rsp_data),
        .rsp_last     (rsp_last),
        .busy         (busy),
        .err_orphan   (err_orphan)
`ifdef RELU_SHARE_ARB_PERF_EN
        ,
        .perf_clr     (perf_clr),
        .perf_cnt     (perf_cnt)
`endif
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] relu_sat(input logic [31:0] w);
        if ($signed(w) < 0)   return 8'h00;
        if ($signed(w) > 255) return 8'hFF;
        return w[7:0];
    endfunction

    // ---------------- requester drivers ----------------
    logic [31:0] src_data [NREQ][SRCN];
    bit          src_last [NREQ][SRCN];
    bit          src_v    [NREQ][SRCN];
    int          src_hd   [NREQ];
    int          src_tl   [NREQ];
    logic [NREQ-1:0] gap_drv;

    int  stub_lat = 3;
    bit  inj_orphan = 1'b0;
    int  cyc = 0;
    int  due_q[$];
    logic [31:0] stub_q[$];

    task automatic add_word(input int r, input logic [31:0] d, input bit last);
        src_data[r][src_tl[r]] = d;
        src_last[r][src_tl[r]] = last;
        src_v[r][src_tl[r]]    = 1'b1;
        src_tl[r]++;
    endtask

    task automatic add_gap(input int r);
        src_data[r][src_tl[r]] = '0;
        src_last[r][src_tl[r]] = 1'b0;
        src_v[r][src_tl[r]]    = 1'b0;
        src_tl[r]++;
    endtask

    task automatic reset_src();
        for (int i = 0; i < NREQ; i++) begin
            src_hd[i] = 0;
            src_tl[i] = 0;
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            if (src_hd[i] != src_tl[i]) begin
                req_vld[i]          = src_v[i][src_hd[i]];
                req_last[i]         = src_last[i][src_hd[i]];
                req_data[32*i +: 32] = src_data[i][src_hd[i]];
                gap_drv[i]          = !src_v[i][src_hd[i]];
            end else begin
                req_vld[i]          = 1'b0;
                req_last[i]         = 1'b0;
                req_data[32*i +: 32] = '0;
                gap_drv[i]          = 1'b0;
            end
        end
    endtask

    // One cycle: retire handshaken/gap entries, re-drive, and run the stub activation unit.
    task automatic step();
        logic [NREQ-1:0] hs_mask;
        logic [NREQ-1:0] gap_mask;
        logic [31:0]     w;
        @(negedge clk);
        hs_mask  = req_vld & req_rdy;
        gap_mask = gap_drv;
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < NREQ; i++)
            if ((hs_mask[i] || gap_mask[i]) && src_hd[i] != src_tl[i]) src_hd[i]++;
        drive();
        if (act_vld) begin
            due_q.push_back(cyc + stub_lat);
            stub_q.push_back(act_data);
        end
        act_res_vld  = inj_orphan;
        act_res_data = '0;
        if (due_q.size() > 0 && due_q[0] == cyc) begin
            void'(due_q.pop_front());
            w = stub_q.pop_front();
            act_res_vld  = 1'b1;
            act_res_data = relu_sat(w);
        end
    endtask

    // ---------------- model + scoreboard ----------------
    logic [IDW:0] exp_q[$];
    bit           m_lock;
    int           m_owner;
    int           m_ptr;
    bit           m_orphan;
    bit           act_exp;
    logic [31:0]  act_exp_d;
    logic [IDW:0] act_exp_tag;
    bit           rsp_exp;
    logic [IDW:0] rsp_exp_tag;
    logic [7:0]   rsp_exp_d;

    logic [31:0]  act_log[$];
    logic [IDW:0] rsp_tag_log[$];
    logic [7:0]   rsp_d_log[$];
    int           hs_log[$];
    int           issued_pre_res;
    bit           seen_res;

    task automatic clear_logs();
        act_log.delete();
        rsp_tag_log.delete();
        rsp_d_log.delete();
        hs_log.delete();
        issued_pre_res = 0;
        seen_res = 1'b0;
    endtask

    always @(negedge clk) begin
        int g;
        bit hs;
        logic [NREQ-1:0] exp_rdy;
        if (!rst_b) begin
            chk("rst_req_rdy", req_rdy, 0);
            chk("rst_act_vld", act_vld, 0);
            chk("rst_act_data", act_data, 0);
            chk("rst_rsp_vld", rsp_vld, 0);
            chk("rst_rsp_fields", {rsp_id, rsp_data, rsp_last}, 0);
            chk("rst_busy", busy, 0);
            chk("rst_err_orphan", err_orphan, 0);
            exp_q.delete();
            m_lock = 1'b0; m_owner = 0; m_ptr = 0; m_orphan = 1'b0;
            act_exp = 1'b0; rsp_exp = 1'b0;
        end else begin
            chk("act_vld", act_vld, act_exp);
            if (act_exp) begin
                chk("act_data", act_data, act_exp_d);
                act_log.push_back(act_data);
            end
            chk("rsp_vld", rsp_vld, rsp_exp);
            if (rsp_exp) begin
                chk("rsp_id", rsp_id, rsp_exp_tag[IDW:1]);
                chk("rsp_last", rsp_last, rsp_exp_tag[0]);
                chk("rsp_data", rsp_data, rsp_exp_d);
                rsp_tag_log.push_back({rsp_id, rsp_last});
                rsp_d_log.push_back(rsp_data);
            end
            chk("err_orphan", err_orphan, m_orphan);
            chk("busy", busy, m_lock || exp_q.size() != 0);

            g = -1;
            if (exp_q.size() + int'(act_exp) < TAGD) begin
                if (m_lock) g = m_owner;
                else
                    for (int k = NREQ - 1; k >= 0; k--)
                        if (req_vld[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
            end
            exp_rdy = '0;
            if (g >= 0) exp_rdy[g] = 1'b1;
            chk("req_rdy", req_rdy, exp_rdy);
            hs = (g >= 0) && req_vld[g];

            if (act_res_vld && !seen_res) seen_res = 1'b1;
            if (act_vld && !seen_res) issued_pre_res++;

            rsp_exp = 1'b0;
            if (act_res_vld) begin
                if (exp_q.size() > 0) begin
                    rsp_exp     = 1'b1;
                    rsp_exp_tag = exp_q.pop_front();
                    rsp_exp_d   = act_res_data;
                end else begin
                    m_orphan = 1'b1;
                end
            end
            if (act_exp) exp_q.push_back(act_exp_tag);

            act_exp = hs;
            if (hs) begin
                act_exp_d   = req_data[32*g +: 32];
                act_exp_tag = {IDW'(g), req_last[g]};
                hs_log.push_back(g);
                if (req_last[g]) begin
                    m_lock = 1'b0;
                    m_ptr  = (g + 1) % NREQ;
                end else begin
                    m_lock  = 1'b1;
                    m_owner = g;
                end
            end
        end
    end

    task automatic wait_rsp(input string name, input int n, input int budget);
        int k = 0;
        while (rsp_d_log.size() < n && k < budget) begin
            step();
            k++;
        end
        chk(name, rsp_d_log.size() >= n, 1);
        repeat (4) step();
    endtask

    // ---------------- directed tests ----------------
    initial begin
        int n3;
        req_vld = '0; req_last = '0; req_data = '0; gap_drv = '0;
        act_res_vld = 1'b0; act_res_data = '0;
`ifdef RELU_SHARE_ARB_PERF_EN
        perf_clr = 1'b0;
`endif
        reset_src();
        repeat (3) step();
        rst_b = 1'b1;
        step();

        // 1: four single words, all valid together
        clear_logs();
        reset_src();
        add_word(0, 32'h10, 1); add_word(1, 32'h20, 1);
        add_word(2, 32'h30, 1); add_word(3, 32'h40, 1);
        wait_rsp("t1_done", 4, 50);
        chk("t1_hs_cnt", hs_log.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk("t1_act_order", act_log[i], 32'h10 * (i + 1));
            chk("t1_rsp_tag", rsp_tag_log[i], {IDW'(i), 1'b1});
            chk("t1_rsp_data", rsp_d_log[i], 8'h10 * (i + 1));
        end

        // 2: burst from 1 (with an owner gap) while 2 waits
        clear_logs();
        reset_src();
        add_word(1, 32'h51, 0); add_word(1, 32'h52, 0); add_gap(1);
        add_word(1, 32'h53, 0); add_word(1, 32'h54, 1);
        add_word(2, 32'h60, 1);
        wait_rsp("t2_done", 5, 60);
        chk("t2_hs_cnt", hs_log.size(), 5);
        for (int i = 0; i < 4; i++) begin
            chk("t2_hs_owner", hs_log[i], 1);
            chk("t2_rsp_tag", rsp_tag_log[i], {2'd1, 1'(i == 3)});
        end
        chk("t2_hs_next", hs_log[4], 2);
        chk("t2_rsp_tag_r2", rsp_tag_log[4], {2'd2, 1'b1});

        // 3: relu/saturate values
        clear_logs();
        reset_src();
        add_word(0, 32'hFFFF_FF00, 1); add_word(1, 32'h0000_0123, 1); add_word(2, 32'h0000_0042, 1);
        wait_rsp("t3_done", 3, 50);
        chk("t3_d0", rsp_d_log[0], 8'h00);
        chk("t3_d1", rsp_d_log[1], 8'hFF);
        chk("t3_d2", rsp_d_log[2], 8'h42);
        chk("t3_id0", rsp_tag_log[0], {2'd0, 1'b1});
        chk("t3_id2", rsp_tag_log[2], {2'd2, 1'b1});

        // 4: long latency fills the tag FIFO
        clear_logs();
        reset_src();
        stub_lat = 12;
        for (int i = 0; i < 20; i++) add_word(0, 32'(i), 1);
        wait_rsp("t4_done", 20, 400);
        chk("t4_inflight_cap", issued_pre_res, 8);
        chk("t4_rsp_cnt", rsp_d_log.size(), 20);
        chk("t4_last_data", rsp_d_log[19], 8'h13);

        // 5: orphan result
        clear_logs();
        inj_orphan = 1'b1;
        step();
        inj_orphan = 1'b0;
        step();
        chk("t5_orphan_set", err_orphan, 1);
        repeat (5) step();
        chk("t5_orphan_sticky", err_orphan, 1);
        chk("t5_no_rsp", rsp_d_log.size(), 0);

        // 6: reset mid-burst with words in flight
        clear_logs();
        reset_src();
        add_word(2, 32'h70, 1);
        wait_rsp("t6_pre", 1, 60);
        for (int i = 0; i < 6; i++) add_word(3, 32'h80 + 32'(i), 1'(i == 5));
        n3 = 0;
        for (int k = 0; k < 40 && n3 < 3; k++) begin
            step();
            n3 = 0;
            foreach (hs_log[j]) if (hs_log[j] == 3) n3++;
        end
        chk("t6_three_issued", n3, 3);
        rst_b = 1'b0;
        step();
        reset_src();
        drive();
        step();
        rst_b = 1'b1;
        step();
        chk("t6_post_busy", busy, 0);
        chk("t6_post_act_vld", act_vld, 0);
        chk("t6_post_rdy", req_rdy, 0);
        repeat (16) step();
        chk("t6_stale_orphan", err_orphan, 1);
        clear_logs();
        add_word(1, 32'h91, 1); add_word(3, 32'h93, 1);
        wait_rsp("t6_new", 2, 60);
        chk("t6_first_grant", hs_log[0], 1);
        chk("t6_second_grant", hs_log[1], 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
